lcm_gcd_unit: RTL and testbench
===============================

// Module: lcm_gcd_unit
// PURPOSE
//  Iterative GCD/LCM engine with start/done handshake, add/subtract/compare datapath only.
//  Generalises the fixed 32-bit LCM FSM: parametrised width, runtime mode select,
//  overflow detection, zero-operand handling, iteration count. Sits behind the exam
//  arithmetic units; result held until next accepted start.
// PARAMETERS
//  WIDTH  32  operand/result width (>=2)
//  CNT_W  16  iteration counter width
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, synchronous, active-high
//  start       in   1      request; accepted only when ready=1
//  mode        in   1      0=GCD, 1=LCM; sampled with start
//  a           in   WIDTH  operand A, sampled with start
//  b           in   WIDTH  operand B, sampled with start
//  ready       out  1      1 in IDLE or DONE (can accept start)
//  busy        out  1      1 in RUN
//  done        out  1      one-cycle pulse in DONE
//  result      out  WIDTH  GCD/LCM value; valid from done, held until next accepted start
//  ovf         out  1      LCM overflowed WIDTH; valid/held like result
//  iter_count  out  CNT_W  iterations used, saturating at all-ones; held like result
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, result=0, ovf=0, iter_count=0; ready=1. rst mid-RUN aborts, no done.
//  States: IDLE -> RUN on start; RUN -> RUN while ma!=mb; RUN -> DONE on terminate; DONE -> IDLE.
//    start in DONE is accepted (DONE -> RUN directly). start in RUN is ignored, no queuing.
//  Accept (edge T): ra<=a, rb<=b, ma<=a, mb<=b, md<=mode, iter<=0, ovf<=0, result<=0.
//  RUN cycle, priority order:
//   1. ra==0 or rb==0: result<=GCD ? (ra|rb) : 0; -> DONE (gcd(0,0)=0).
//   2. ma==mb: result<=ma; -> DONE.
//   3. GCD: ma>mb ? ma<=ma-mb : mb<=mb-ma.
//      LCM: ma<mb ? ma<=ma+ra : mb<=mb+rb; sum in WIDTH+1 bits;
//      carry out -> ovf<=1, result<=0, -> DONE.
//   4. A step that performs an update does iter<=iter+1, saturating.
//  Latency: start at edge T, k iterations -> done high in cycle T+k+2. Zero/equal operands: k=0.
//  iter_count<=iter on entry to DONE. ovf never set in GCD mode.
//  Termination guaranteed: GCD strictly decreases; LCM strictly increases or overflows.
//  ready and busy are decoded from the state register. done, result, ovf and iter_count are registered.
// STRUCTURE
//  lcm_pkg: state enum {IDLE, RUN, DONE} (2-bit), mode constants MODE_GCD=1'b0, MODE_LCM=1'b1.
//  Single module: FSM plus one shared magnitude comparator and one add/sub datapath.
//  No sub-module needed.
// TESTING
//  LCM a=4 b=6 -> done at T+5, result=12, iter_count=3, ovf=0.
//  GCD a=48 b=18 -> result=6, iter_count=4, done at T+6.
//  WIDTH=8, LCM a=255 b=254 -> ovf=1, result=0, single done pulse.
//  a=0 b=9: GCD -> result=9; LCM -> result=0; both iter_count=0, done at T+2.
//  a=b=7: LCM -> result 7, iter 0. start pulsed during RUN -> ignored, first result intact.
//  rst in cycle T+2 of LCM(4,6) -> IDLE, outputs zero, no done; fresh start then works.
//  Back-to-back: start asserted in the DONE cycle -> accepted, second result correct.

Source files
------------

// File: rtl/lcm_pkg.sv
// Shared types and constants for the iterative GCD/LCM engine.
package lcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_GCD = 1'b0;
  localparam logic MODE_LCM = 1'b1;

endpackage

// File: rtl/lcm_gcd_unit.sv
// Iterative GCD/LCM engine: subtractive GCD or additive LCM on one shared
// comparator and one add/sub unit, with start/done handshake, overflow flag
// and a saturating iteration counter.
module lcm_gcd_unit
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [CNT_W-1:0] iter_count
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] ra_q, rb_q, ma_q, mb_q;
  logic             md_q;
  logic [CNT_W-1:0] iter_q;

  logic             accept;
  logic             zero_op, eq, lt, upd_a, is_gcd, carry, term;
  logic [WIDTH-1:0] op_x, op_y;
  logic [WIDTH:0]   sum;

  assign accept = start && ready;
  assign is_gcd = (md_q == MODE_GCD);

  // Shared comparator and add/sub datapath
  always_comb begin
    zero_op = (ra_q == '0) || (rb_q == '0);
    eq      = (ma_q == mb_q);
    lt      = (ma_q < mb_q);
    // GCD shrinks the larger value; LCM grows the smaller one
    upd_a   = is_gcd ? !lt : lt;
    op_x    = upd_a ? ma_q : mb_q;
    if (is_gcd) begin
      op_y = upd_a ? mb_q : ma_q;
      sum  = {1'b0, op_x} - {1'b0, op_y};
    end else begin
      op_y = upd_a ? ra_q : rb_q;
      sum  = {1'b0, op_x} + {1'b0, op_y};
    end
    carry = !is_gcd && sum[WIDTH];
    term  = zero_op || eq || carry;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (term) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    busy  = (state_q == RUN);
  end

  // Operand registers, iteration counter and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q       <= '0;
      rb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      md_q       <= MODE_GCD;
      iter_q     <= '0;
      done       <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
      iter_count <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ra_q       <= a;
        rb_q       <= b;
        ma_q       <= a;
        mb_q       <= b;
        md_q       <= mode;
        iter_q     <= '0;
        ovf        <= 1'b0;
        result     <= '0;
        iter_count <= '0;
      end else if (state_q == RUN) begin
        if (zero_op) begin
          result     <= is_gcd ? (ra_q | rb_q) : '0;
          iter_count <= iter_q;
          done       <= 1'b1;
        end else if (eq) begin
          result     <= ma_q;
          iter_count <= iter_q;
          done       <= 1'b1;
        end else if (carry) begin
          ovf        <= 1'b1;
          result     <= '0;
          iter_count <= iter_q;
          done       <= 1'b1;
        end else begin
          if (upd_a) ma_q <= sum[WIDTH-1:0];
          else       mb_q <= sum[WIDTH-1:0];
          if (iter_q != '1) iter_q <= iter_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcm_gcd_unit.sv
// Self-checking bench for lcm_gcd_unit (WIDTH=8): directed corner cases plus
// randomized operands against an arithmetic GCD/LCM reference.
module tb_lcm_gcd_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAX_CYC = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a, b;
  logic             ready, busy, done, ovf;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] iter_count;

  int total = 0;
  int bad   = 0;

  lcm_gcd_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid with remainders; quotient sum gives subtractive step count
  task automatic model(input bit m, input int unsigned x, input int unsigned y,
                       output int unsigned res, output bit v, output int unsigned k);
    int unsigned p, q, qs, g, l;
    v = 0;
    k = 0;
    if (x == 0 || y == 0) begin
      res = m ? 0 : (x | y);
      return;
    end
    p = x; q = y; qs = 0;
    while (q != 0) begin
      int unsigned t;
      qs += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    g = p;
    if (!m) begin
      res = g;
      k   = qs - 1;
    end else begin
      l = (x * y) / g;
      if (l > 255) begin
        v   = 1;
        res = 0;
      end else begin
        res = l;
        k   = l / x + l / y - 2;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle
  task automatic run_op(input bit m, input int unsigned x, input int unsigned y,
                        output int unsigned lat, output bit timeout);
    check("ready_at_start", 32'(ready), 32'd1);
    start = 1'b1;
    mode  = m;
    a     = WIDTH'(x);
    b     = WIDTH'(y);
    @(negedge clk);
    start = 1'b0;
    check("busy_in_run", 32'(busy), 32'd1);
    lat = 0;
    timeout = 0;
    while (!done && lat < MAX_CYC) begin
      @(negedge clk);
      lat++;
    end
    if (!done) timeout = 1;
    check("done_timeout", 32'(timeout), 32'd0);
  endtask

  task automatic check_op(input string tag, input bit m, input int unsigned x,
                          input int unsigned y);
    int unsigned res, k, lat;
    bit v, to;
    model(m, x, y, res, v, k);
    run_op(m, x, y, lat, to);
    if (!to) begin
      check({tag, "_result"}, 32'(result), res);
      check({tag, "_ovf"}, 32'(ovf), 32'(v));
      if (!v) begin
        check({tag, "_iter"}, 32'(iter_count), k);
        check({tag, "_latency"}, lat, k + 1);
      end
    end
  endtask

  initial begin
    int unsigned seen;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_iter", 32'(iter_count), 32'd0);

    @(negedge clk);
    check_op("lcm_4_6", 1'b1, 4, 6);
    check("lcm_4_6_res_abs", 32'(result), 32'd12);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check_op("gcd_48_18", 1'b0, 48, 18);
    check("gcd_48_18_iter_abs", 32'(iter_count), 32'd4);
    @(negedge clk);

    check_op("lcm_ovf", 1'b1, 255, 254);
    check("ovf_abs", 32'(ovf), 32'd1);
    @(negedge clk);
    check("ovf_single_done", 32'(done), 32'd0);
    check("ovf_held", 32'(ovf), 32'd1);

    check_op("gcd_0_9", 1'b0, 0, 9);
    check_op("lcm_0_9", 1'b1, 0, 9);
    check_op("gcd_0_0", 1'b0, 0, 0);
    check_op("lcm_7_7", 1'b1, 7, 7);
    // Back-to-back: start issued in the DONE cycle of the previous op
    check_op("b2b_gcd", 1'b0, 36, 24);
    @(negedge clk);

    // start during RUN must be ignored
    start = 1'b1; mode = 1'b1; a = 8'd4; b = 8'd6;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'd9; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    while (!done && seen < MAX_CYC) begin
      @(negedge clk);
      seen++;
    end
    check("ignore_done_seen", 32'(done), 32'd1);
    check("ignore_result", 32'(result), 32'd12);
    check("ignore_iter", 32'(iter_count), 32'd3);
    @(negedge clk);

    // Synchronous reset in cycle T+2 of LCM(4,6)
    start = 1'b1; mode = 1'b1; a = 8'd4; b = 8'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_iter", 32'(iter_count), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 32'd0);
    check_op("after_abort", 1'b1, 4, 6);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      int unsigned x, y;
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) x = 0;
      if (i % 3 == 2) y = x;
      check_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), x, y);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
